// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   REG_IDX_W  - width of an architectural register index
//   hz_state_e - hazard FSM state encoding (2 bits)
package pipe_ctrl_pkg;

  localparam int unsigned REG_IDX_W = 5;

  typedef enum logic [1:0] {
    StRun       = 2'd0,
    StMemWait   = 2'd1,
    StFetchWait = 2'd2,
    StFlush     = 2'd3
  } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
//   Pipeline -> controller: ID sources/use flags, EX rd/load/branch, imem_ready, dmem_busy
//   Controller -> pipeline: pc_stall, ifid_stall/flush, idex_stall/flush, fetch_abort
//   With PIPE_HAZARD_PERF_EN defined: perf_stall_cnt, perf_flush_cnt (controller -> pipeline)
// modport slave is the controller side, modport master is the datapath side.
interface pipe_hazard_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic [REG_IDX_W-1:0] id_rs1;
  logic [REG_IDX_W-1:0] id_rs2;
  logic                 id_use_rs1;
  logic                 id_use_rs2;
  logic [REG_IDX_W-1:0] ex_rd;
  logic                 ex_mem_read;
  logic                 ex_br_taken;
  logic                 imem_ready;
  logic                 dmem_busy;

  logic                 pc_stall;
  logic                 ifid_stall;
  logic                 ifid_flush;
  logic                 idex_stall;
  logic                 idex_flush;
  logic                 fetch_abort;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0]          perf_stall_cnt;
  logic [31:0]          perf_flush_cnt;
`endif

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read, ex_br_taken,
    input  imem_ready, dmem_busy,
`ifdef PIPE_HAZARD_PERF_EN
    output perf_stall_cnt, perf_flush_cnt,
`endif
    output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, fetch_abort
  );

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read, ex_br_taken,
    output imem_ready, dmem_busy,
`ifdef PIPE_HAZARD_PERF_EN
    input  perf_stall_cnt, perf_flush_cnt,
`endif
    input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, fetch_abort
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use comparator: flags when the instruction in ID reads the destination of a
// load sitting in EX. x0 never hazards. Purely combinational.
//   rs1, rs2, use_rs1, use_rs2 : ID source registers and their use flags
//   rd, mem_read               : EX destination and load flag
//   lu                         : hazard present
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  input  logic                 use_rs1,
  input  logic                 use_rs2,
  input  logic [REG_IDX_W-1:0] rd,
  input  logic                 mem_read,
  output logic                 lu
);

  assign lu = mem_read && (rd != '0) &&
              ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller: owns PC hold, IF/ID and ID/EX stall/flush and fetch abort.
// One FSM (RUN, MEM_WAIT, FETCH_WAIT, FLUSH) plus a 2-bit flush down-counter.
// Outputs are combinational from state and inputs.
//   clk, rst_n : clock, synchronous active-low reset
//   hif        : pipe_hazard_ctrl_if.slave bundle
//   FLUSH_CYCLES (1..3): IF/ID bubbles inserted per taken branch
// Optional macro PIPE_HAZARD_PERF_EN adds saturating stall/flush cycle counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave hif
);

  localparam logic [1:0] FlushReload = 2'(FLUSH_CYCLES - 1);
  localparam bit         MultiFlush  = (FLUSH_CYCLES > 1);

  hz_state_e  state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       lu;
  logic       run_rules, flush_rules;
  logic       pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, fetch_abort;

  hazard_detect u_hazard_detect (
    .rs1      (hif.id_rs1),
    .rs2      (hif.id_rs2),
    .use_rs1  (hif.id_use_rs1),
    .use_rs2  (hif.id_use_rs2),
    .rd       (hif.ex_rd),
    .mem_read (hif.ex_mem_read),
    .lu       (lu)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    run_rules   = 1'b0;
    flush_rules = 1'b0;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    fetch_abort = 1'b0;

    unique case (state_q)
      StRun: run_rules = 1'b1;
      StMemWait: begin
        if (hif.dmem_busy) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_stall = 1'b1;
        end else if (cnt_q != 2'd0) begin
          // Resume an interrupted branch flush in the release cycle so no
          // wrong-path instruction slips into IF/ID.
          flush_rules = 1'b1;
        end else begin
          run_rules = 1'b1;
        end
      end
      StFetchWait: begin
        if (hif.dmem_busy) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_stall = 1'b1;
          state_d    = StMemWait;
        end else if (hif.ex_br_taken) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          fetch_abort = 1'b1;
          state_d     = MultiFlush ? StFlush : StRun;
          cnt_d       = FlushReload;
        end else if (!hif.imem_ready) begin
          pc_stall   = 1'b1;
          ifid_flush = 1'b1;
        end else begin
          state_d = StRun;
        end
      end
      StFlush: begin
        if (hif.dmem_busy) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_stall = 1'b1;
          state_d    = StMemWait;
        end else begin
          flush_rules = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase

    if (run_rules) begin
      if (hif.dmem_busy) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_stall = 1'b1;
        state_d    = StMemWait;
      end else if (hif.ex_br_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        state_d    = MultiFlush ? StFlush : StRun;
        cnt_d      = FlushReload;
      end else if (lu) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
        state_d    = StRun;
      end else if (!hif.imem_ready) begin
        pc_stall   = 1'b1;
        ifid_flush = 1'b1;
        state_d    = StFetchWait;
      end else begin
        state_d = StRun;
      end
    end

    if (flush_rules) begin
      ifid_flush = 1'b1;
      if (hif.ex_br_taken) begin
        // A new taken branch restarts the bubble sequence from this cycle.
        idex_flush = 1'b1;
        state_d    = MultiFlush ? StFlush : StRun;
        cnt_d      = FlushReload;
      end else if (cnt_q <= 2'd1) begin
        state_d = StRun;
        cnt_d   = 2'd0;
      end else begin
        state_d = StFlush;
        cnt_d   = cnt_q - 2'd1;
      end
    end

    if (!rst_n) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b1;
      idex_stall  = 1'b0;
      idex_flush  = 1'b1;
      fetch_abort = 1'b0;
    end
  end

  assign hif.pc_stall    = pc_stall;
  assign hif.ifid_stall  = ifid_stall;
  assign hif.ifid_flush  = ifid_flush;
  assign hif.idex_stall  = idex_stall;
  assign hif.idex_flush  = idex_flush;
  assign hif.fetch_abort = fetch_abort;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      if (pc_stall && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
      if (ifid_flush && (perf_flush_q != '1)) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign hif.perf_stall_cnt = perf_stall_q;
  assign hif.perf_flush_cnt = perf_flush_q;
`endif

endmodule
